// File: rtl/msrv32_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | msrv32_pkg : shared ALU opcodes, port indices and scheduler state     |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
package msrv32_pkg;

  // Opcode layout is {funct7[5], funct3}
  localparam logic [3:0] C_ALU_ADD  = 4'b0000;
  localparam logic [3:0] C_ALU_SUB  = 4'b1000;
  localparam logic [3:0] C_ALU_SLL  = 4'b0001;
  localparam logic [3:0] C_ALU_SLT  = 4'b0010;
  localparam logic [3:0] C_ALU_SLTU = 4'b0011;
  localparam logic [3:0] C_ALU_XOR  = 4'b0100;
  localparam logic [3:0] C_ALU_SRL  = 4'b0101;
  localparam logic [3:0] C_ALU_SRA  = 4'b1101;
  localparam logic [3:0] C_ALU_OR   = 4'b0110;
  localparam logic [3:0] C_ALU_AND  = 4'b0111;

  localparam logic C_P0 = 1'b0;
  localparam logic C_P1 = 1'b1;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/msrv32_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | msrv32_alu : 32-bit combinational integer ALU                         |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
module msrv32_alu
  import msrv32_pkg::*;
(
  input  logic [31:0] i_op1,
  input  logic [31:0] i_op2,
  input  logic [3:0]  i_opcode,
  output logic [31:0] o_result
);

  logic [4:0] w_shamt;
  assign w_shamt = i_op2[4:0];

  always_comb begin
    o_result = '0;
    case (i_opcode)
      C_ALU_ADD:  o_result = i_op1 + i_op2;
      C_ALU_SUB:  o_result = i_op1 - i_op2;
      C_ALU_SLL:  o_result = i_op1 << w_shamt;
      C_ALU_SLT:  o_result = {31'b0, $signed(i_op1) < $signed(i_op2)};
      C_ALU_SLTU: o_result = {31'b0, i_op1 < i_op2};
      C_ALU_XOR:  o_result = i_op1 ^ i_op2;
      C_ALU_SRL:  o_result = i_op1 >> w_shamt;
      C_ALU_SRA:  o_result = $signed(i_op1) >>> w_shamt;
      C_ALU_OR:   o_result = i_op1 | i_op2;
      C_ALU_AND:  o_result = i_op1 & i_op2;
      default:    o_result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/msrv32_alu_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | msrv32_alu_scheduler : two-port arbiter sharing one msrv32_alu        |
// | Revision             : 1.0                                            |
// +----------------------------------------------------------------------+
module msrv32_alu_scheduler
  import msrv32_pkg::*;
#(
  parameter int PRIORITY_MODE = 0,
  parameter int CNT_W         = 16
) (
  input  logic             ms_riscv32_mp_clk_in,
  input  logic             ms_riscv32_mp_rst_n_in,
  input  logic [1:0]       req_valid_in,
  output logic [1:0]       req_ready_out,
  input  logic [31:0]      req_op1_p0_in,
  input  logic [31:0]      req_op2_p0_in,
  input  logic [31:0]      req_op1_p1_in,
  input  logic [31:0]      req_op2_p1_in,
  input  logic [3:0]       req_opcode_p0_in,
  input  logic [3:0]       req_opcode_p1_in,
  output logic [1:0]       rsp_valid_out,
  input  logic [1:0]       rsp_ready_in,
  output logic [31:0]      result_out,
  output logic [CNT_W-1:0] grant_cnt_p0_out,
  output logic [CNT_W-1:0] grant_cnt_p1_out
);

  sched_state_e     r_state;
  logic             r_owner;
  logic [31:0]      r_result;
  logic             r_last_grant;
  logic [CNT_W-1:0] r_cnt_p0;
  logic [CNT_W-1:0] r_cnt_p1;

  logic        w_drain;
  logic        w_free;
  logic        w_winner;
  logic        w_accept;
  logic [31:0] w_alu_op1;
  logic [31:0] w_alu_op2;
  logic [3:0]  w_alu_opcode;
  logic [31:0] w_alu_result;

  assign w_drain = (r_state == ST_FULL) && rsp_ready_in[r_owner];
  assign w_free  = (r_state == ST_EMPTY) || w_drain;

  always_comb begin
    w_winner = C_P0;
    case (req_valid_in)
      2'b10:   w_winner = C_P1;
      2'b11:   w_winner = (PRIORITY_MODE != 0) ? C_P0 : !r_last_grant;
      default: w_winner = C_P0;
    endcase
  end

  // Any valid port implies the winner itself is valid
  assign w_accept = w_free && (|req_valid_in);

  assign req_ready_out = {2{ms_riscv32_mp_rst_n_in}} &
                         {w_accept && (w_winner == C_P1), w_accept && (w_winner == C_P0)};

  assign w_alu_op1    = (w_winner == C_P1) ? req_op1_p1_in    : req_op1_p0_in;
  assign w_alu_op2    = (w_winner == C_P1) ? req_op2_p1_in    : req_op2_p0_in;
  assign w_alu_opcode = (w_winner == C_P1) ? req_opcode_p1_in : req_opcode_p0_in;

  msrv32_alu u_alu (
    .i_op1    (w_alu_op1),
    .i_op2    (w_alu_op2),
    .i_opcode (w_alu_opcode),
    .o_result (w_alu_result)
  );

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      r_state      <= ST_EMPTY;
      r_owner      <= C_P0;
      r_result     <= '0;
      r_last_grant <= C_P1;
      r_cnt_p0     <= '0;
      r_cnt_p1     <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) r_state <= ST_FULL;
        end
        ST_FULL: begin
          // A drain paired with a new accept keeps the register full
          if (w_drain && !w_accept) r_state <= ST_EMPTY;
        end
        default: r_state <= ST_EMPTY;
      endcase
      if (w_accept) begin
        r_result     <= w_alu_result;
        r_owner      <= w_winner;
        r_last_grant <= w_winner;
        if (w_winner == C_P0) begin
          if (r_cnt_p0 != {CNT_W{1'b1}}) r_cnt_p0 <= r_cnt_p0 + CNT_W'(1);
        end else begin
          if (r_cnt_p1 != {CNT_W{1'b1}}) r_cnt_p1 <= r_cnt_p1 + CNT_W'(1);
        end
      end
    end
  end

  assign rsp_valid_out    = (r_state == ST_FULL) ? {r_owner, !r_owner} : 2'b00;
  assign result_out       = r_result;
  assign grant_cnt_p0_out = r_cnt_p0;
  assign grant_cnt_p1_out = r_cnt_p1;

endmodule
`default_nettype wire
